spi_burst_ctrl: RTL and testbench
=================================

# spi_burst_ctrl

Burst controller that sits directly upstream of the byte-level SPI master, and feeds it. It accepts a command giving a burst length and takes TX bytes from a local FIFO. It drives the master's enable/byte handshake so that all bytes go out back-to-back under one SS assertion, and collects every received byte into an RX FIFO. Software or a bus bridge sees only two FIFOs and a command port.

## Interface
- `DEPTH`, 16: entries per FIFO; power of two, ≥ 2.
- `LEN_W`, 8: width of `cmd_len`; a burst carries `cmd_len`+1 bytes (1..2^LEN_W).
- `clk`  in  1  single clock for the block and the downstream master.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  burst request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_len`  in  LEN_W  bytes in burst minus one.
- `tx_wr`  in  1  push `tx_data` into TX FIFO.
- `tx_data`  in  8  byte to transmit.
- `tx_full`  out  1  TX FIFO full.
- `rx_rd`  in  1  pop RX FIFO.
- `rx_data`  out  8  RX FIFO head (first-word fall-through).
- `rx_empty`  out  1  RX FIFO empty.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last RX byte is stored.
- `underrun`, `overflow`  out  1 each  sticky error flags; see Configuration.
- `spi_en`  out  1  to master enable.
- `spi_tx_byte`  out  8  to master TX byte.
- `spi_tx_ready`  in  1  master pulse: current byte latched, shifting begun.
- `spi_rx_byte`  in  8  master received byte.
- `spi_rx_ready`  in  1  master pulse: `spi_rx_byte` valid.

## Operation
- **Reset values:** all outputs 0 except `cmd_ready`=1 and `rx_empty`=1; FIFOs empty; state IDLE.
- **States:** IDLE, FEED, DRAIN, DONE.
- **IDLE:**
  - On `cmd_valid`: load `tx_left`=`cmd_len` and `rx_left`=`cmd_len`.
  - Pop TX head into `spi_tx_byte`, or FILL_BYTE 8'hFF if the FIFO is empty; an empty FIFO sets `underrun`.
  - Set `spi_en`=1 and go to FEED.
- **FEED:**
  - On `spi_tx_ready` with `tx_left`==0: clear `spi_en` and go to DRAIN.
  - On `spi_tx_ready` otherwise: pop the next byte (FILL_BYTE and `underrun` if empty) into `spi_tx_byte` and decrement `tx_left`.
  - `spi_en` stays high throughout, so bytes stream without SS release.
- **RX path, any non-IDLE state:** each `spi_rx_ready` writes `spi_rx_byte` to the RX FIFO. If the FIFO is full, the byte is dropped and `overflow` is set.
- **Byte counting:** each `spi_rx_ready` decrements `rx_left`. `rx_ready` when `rx_left`==0 moves FEED/DRAIN to DONE; this path is normally reached from DRAIN.
- **DONE:** pulse `done` for one cycle, then go to IDLE.
- **FIFOs:**
  - Simultaneous push and pop is legal in every fill state.
  - A push when full is ignored.
  - `rx_rd` when empty is ignored; `rx_data` holds its last value.
- **Counters:** `tx_left` and `rx_left` are LEN_W wide and never wrap, because they are decremented only while nonzero.
- **Reset mid-burst:** `spi_en` drops immediately (asynchronously), FIFOs flush, and the block returns to IDLE. Partial RX data is lost.

## Timing
- `cmd_valid`&`cmd_ready` sampled at edge N → `spi_en`, `spi_tx_byte` valid from N+1 (both registered).
- The next byte is in `spi_tx_byte` one cycle after `spi_tx_ready`. The master relatches it 15 cycles later; 14 cycles of slack.
- `spi_en` falls one cycle after the last `spi_tx_ready`. It must be low before the master's end-of-byte check 15 cycles later.
- RX FIFO write occurs on the edge after `spi_rx_ready`. `done` rises two cycles after the final `spi_rx_ready`.
- A new command may be accepted the cycle `cmd_ready` returns. The master restarts when it next reaches idle, and `spi_en` is held until it does.
- Byte throughput: one byte per 16 cycles within a burst.

## Configuration
- `SPI_BURST_ERR_EN` defined:
  - `underrun` and `overflow` are sticky registers.
  - Both clear on command acceptance or `rst`.
- `SPI_BURST_ERR_EN` undefined:
  - Both outputs are tied 0 and no flag logic is built.
  - FILL_BYTE substitution and RX drop behaviour are unchanged.

## Structure
- **Package `spi_burst_pkg`:** state enum, FILL_BYTE=8'hFF, FIFO pointer-width function.
- **Sub-module `spi_sync_fifo`:**
  - Parameters: DEPTH, WIDTH=8.
  - Ports: first-word fall-through head, `full`, `empty`.
  - Instantiated twice (TX, RX).

## Test plan
- **Single byte:** push 8'hA5, `cmd_len`=0, master model loops MOSI→MISO. Expect one `spi_en` window, RX FIFO gets A5, `done` once, `busy` low after.
- **Four-byte burst:** push 01,02,03,04, `cmd_len`=3. Expect `spi_en` continuously high across 4 `spi_tx_ready` pulses, RX=01..04 in order, `done` at 2 cycles after 4th `rx_ready`.
- **Underrun:** push 1 byte (77), `cmd_len`=2. Expect bytes 77,FF,FF transmitted, `underrun`=1 (macro on) / 0 (macro off).
- **RX overflow:** DEPTH=4, no `rx_rd`, `cmd_len`=5. Expect first 4 bytes kept, last 2 dropped, `overflow`=1, `done` still pulses.
- **Reset mid-burst:** assert `rst` during the 2nd byte of an 8-byte burst. Expect `spi_en`=0 and `rx_empty`=1 immediately, and `cmd_ready`=1 after release.
- **Back-to-back:** issue a second command the cycle after `done`. Expect the second burst to complete with correct data and no spurious `spi_tx_ready` handling.

Source files
------------

// File: rtl/spi_burst_pkg.sv
// Shared types and constants for the SPI burst controller and its FIFOs.
package spi_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sent in place of a real byte when the TX FIFO runs dry mid-burst.
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word fall-through FIFO; when empty the head holds the last popped word.
module spi_sync_fifo
  import spi_burst_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop frees a slot in the same cycle, so a push against a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  // NOTE: the storage array is deliberately not reset; only pointers and count are, so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Streams a counted burst from a TX FIFO through a byte SPI master under one SS window, filling an RX FIFO.
// Define SPI_BURST_ERR_EN to build the sticky underrun/overflow flags; otherwise both outputs are tied low.
module spi_burst_ctrl
  import spi_burst_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             tx_wr,
  input  logic [7:0]       tx_data,
  output logic             tx_full,
  input  logic             rx_rd,
  output logic [7:0]       rx_data,
  output logic             rx_empty,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic             overflow,
  output logic             spi_en,
  output logic [7:0]       spi_tx_byte,
  input  logic             spi_tx_ready,
  input  logic [7:0]       spi_rx_byte,
  input  logic             spi_rx_ready
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] tx_left_q, tx_left_d, rx_left_q, rx_left_d;
  logic             spi_en_q, spi_en_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             done_q;
  logic             tx_pop, tx_empty;
  logic [7:0]       tx_head, next_byte;
  logic             rx_write, rx_push, rx_full;
  logic             accept;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign next_byte = tx_empty ? FILL_BYTE : tx_head;
  assign rx_write  = spi_rx_ready && (state_q != IDLE);
  assign rx_push   = rx_write && (!rx_full || rx_rd);

  spi_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push_i(tx_wr), .push_data_i(tx_data), .pop_i(tx_pop),
    .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  spi_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push_i(rx_push), .push_data_i(spi_rx_byte), .pop_i(rx_rd),
    .head_o(rx_data), .full_o(rx_full), .empty_o(rx_empty)
  );

  always_comb begin
    // NOTE: every comb output takes a default before the case, so no path can infer a latch.
    state_d   = state_q;
    tx_left_d = tx_left_q;
    rx_left_d = rx_left_q;
    spi_en_d  = spi_en_q;
    tx_byte_d = tx_byte_q;
    tx_pop    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        tx_left_d = cmd_len;
        rx_left_d = cmd_len;
        tx_pop    = 1'b1;
        tx_byte_d = next_byte;
        spi_en_d  = 1'b1;
        state_d   = FEED;
      end
      FEED: if (spi_tx_ready) begin
        if (tx_left_q == '0) begin
          spi_en_d = 1'b0;
          state_d  = DRAIN;
        end else begin
          tx_pop    = 1'b1;
          tx_byte_d = next_byte;
          tx_left_d = tx_left_q - LEN_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    // The receive count closes the burst; it overrides any FEED decision taken this cycle.
    if (rx_write) begin
      if (rx_left_q != '0) begin
        rx_left_d = rx_left_q - LEN_W'(1);
      end else if (state_q == FEED || state_q == DRAIN) begin
        spi_en_d = 1'b0;
        state_d  = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_left_q <= '0;
      rx_left_q <= '0;
      spi_en_q  <= 1'b0;
      tx_byte_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_left_q <= tx_left_d;
      rx_left_q <= rx_left_d;
      spi_en_q  <= spi_en_d;
      tx_byte_q <= tx_byte_d;
      done_q    <= (state_q == DONE);
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign spi_en      = spi_en_q;
  assign spi_tx_byte = tx_byte_q;

`ifdef SPI_BURST_ERR_EN
  logic underrun_q, overflow_q;

  // A new error in the accept cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (tx_pop && tx_empty) underrun_q <= 1'b1;
      else if (accept)        underrun_q <= 1'b0;
      if (rx_write && !rx_push) overflow_q <= 1'b1;
      else if (accept)          overflow_q <= 1'b0;
    end
  end

  assign underrun = underrun_q;
  assign overflow = overflow_q;
`else
  assign underrun = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl: loopback SPI master model, table and random bursts, reset corners.
module tb_spi_burst_ctrl;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

`ifdef SPI_BURST_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             tx_wr, tx_full;
  logic [7:0]       tx_data;
  logic             rx_rd, rx_empty;
  logic [7:0]       rx_data;
  logic             busy, done, underrun, overflow;
  logic             spi_en, spi_tx_ready, spi_rx_ready;
  logic [7:0]       spi_tx_byte, spi_rx_byte;

  always #5 clk = ~clk;

  spi_burst_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
    .busy(busy), .done(done), .underrun(underrun), .overflow(overflow),
    .spi_en(spi_en), .spi_tx_byte(spi_tx_byte), .spi_tx_ready(spi_tx_ready),
    .spi_rx_byte(spi_rx_byte), .spi_rx_ready(spi_rx_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Master model and monitor, both acting on the falling edge.
  int         cyc = 0, done_cnt = 0, done_cyc = 0, last_rx_cyc = 0, rx_cnt = 0, en_rises = 0;
  logic       prev_en = 1'b0;
  logic [7:0] sent_q[$];
  bit         m_busy = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = 8'h00;

  initial begin
    spi_tx_ready = 1'b0;
    spi_rx_ready = 1'b0;
    spi_rx_byte  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (spi_en === 1'b1 && !prev_en) en_rises++;
      prev_en      = (spi_en === 1'b1);
      spi_tx_ready = 1'b0;
      spi_rx_ready = 1'b0;
      if (rst) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == 15) begin
          spi_rx_byte  = m_byte;  // MOSI looped to MISO
          spi_rx_ready = 1'b1;
          m_busy       = 1'b0;
          last_rx_cyc  = cyc;
          rx_cnt++;
        end
      end else if (spi_en === 1'b1) begin
        m_byte       = spi_tx_byte;
        spi_tx_ready = 1'b1;
        m_busy       = 1'b1;
        m_cnt        = 0;
        sent_q.push_back(m_byte);
      end
    end
  end

  task automatic clear_mon();
    sent_q.delete();
    done_cnt = 0; done_cyc = 0; last_rx_cyc = 0; rx_cnt = 0; en_rises = 0;
  endtask

  task automatic push_bytes(input logic [7:0] d [8], input int n);
    for (int i = 0; i < n; i++) begin
      tx_wr = 1'b1; tx_data = d[i];
      @(negedge clk);
    end
    tx_wr = 1'b0;
  endtask

  task automatic issue_cmd(input int len);
    cmd_valid = 1'b1; cmd_len = LEN_W'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target, input int bound);
    int t = 0;
    while (done_cnt < target && t < bound) begin @(negedge clk); t++; end
    if (done_cnt < target) check({name, " done timeout"}, 32'(done_cnt), 32'(target));
  endtask

  task automatic drain_rx(input string name, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s rx_empty[%0d]", name, i), 32'(rx_empty), 32'd0);
      check($sformatf("%s rx_data[%0d]", name, i), 32'(rx_data), 32'(exp[i]));
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end
    check({name, " rx_empty after drain"}, 32'(rx_empty), 32'd1);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    check({name, " rx_data held on empty pop"}, 32'(rx_data), 32'(exp[exp.size()-1]));
    check({name, " rx_empty after empty pop"}, 32'(rx_empty), 32'd1);
  endtask

  // Reference: the first min(npush, DEPTH) pushed bytes go out, then FILL bytes up to len+1;
  // the RX FIFO keeps the first DEPTH echoed bytes.
  task automatic run_burst(input string name, input int len, input int npush,
                           input logic [7:0] d [8], input bit exp_starved, input bit exp_dropped);
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    int stored = (npush < DEPTH) ? npush : DEPTH;
    for (int i = 0; i <= len; i++) exp_tx.push_back((i < stored) ? d[i] : 8'hFF);
    for (int i = 0; i <= len && i < DEPTH; i++) exp_rx.push_back(exp_tx[i]);
    clear_mon();
    push_bytes(d, npush);
    check({name, " tx_full"}, 32'(tx_full), 32'(npush >= DEPTH));
    check({name, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
    issue_cmd(len);
    check({name, " busy"}, 32'(busy), 32'd1);
    wait_done(name, 1, 16 * (len + 1) + 40);
    repeat (2) @(negedge clk);
    check({name, " done pulses"}, 32'(done_cnt), 32'd1);
    check({name, " done latency"}, 32'(done_cyc - last_rx_cyc), 32'd2);
    check({name, " spi_en windows"}, 32'(en_rises), 32'd1);
    check({name, " rx_ready count"}, 32'(rx_cnt), 32'(len + 1));
    check({name, " busy after"}, 32'(busy), 32'd0);
    check({name, " spi_en after"}, 32'(spi_en), 32'd0);
    check({name, " bytes sent"}, 32'(sent_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < sent_q.size(); i++)
      check($sformatf("%s tx byte %0d", name, i), 32'(sent_q[i]), 32'(exp_tx[i]));
    check({name, " underrun"}, 32'(underrun), 32'(ERR_ON && exp_starved));
    check({name, " overflow"}, 32'(overflow), 32'(ERR_ON && exp_dropped));
    drain_rx(name, exp_rx);
  endtask

  typedef struct packed {
    logic [7:0]      len;
    logic [2:0]      npush;
    logic            starved;
    logic            dropped;
    logic [4:0][7:0] data;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] d [8];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0;
    tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0;

    vecs[0] = '{len: 8'd0, npush: 3'd1, starved: 1'b0, dropped: 1'b0,
                data: {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
    vecs[1] = '{len: 8'd3, npush: 3'd4, starved: 1'b0, dropped: 1'b0,
                data: {8'h00, 8'h04, 8'h03, 8'h02, 8'h01}};
    vecs[2] = '{len: 8'd2, npush: 3'd1, starved: 1'b1, dropped: 1'b0,
                data: {8'h00, 8'h00, 8'h00, 8'h00, 8'h77}};
    vecs[3] = '{len: 8'd5, npush: 3'd4, starved: 1'b1, dropped: 1'b1,
                data: {8'h00, 8'h3C, 8'h2B, 8'h1A, 8'h09}};
    vecs[4] = '{len: 8'd4, npush: 3'd5, starved: 1'b1, dropped: 1'b1,
                data: {8'hEE, 8'hD4, 8'hC3, 8'hB2, 8'hA1}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset rx_empty", 32'(rx_empty), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset spi_en", 32'(spi_en), 32'd0);
    check("reset spi_tx_byte", 32'(spi_tx_byte), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset tx_full", 32'(tx_full), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 8; i++) d[i] = (i < 5) ? vecs[v].data[i] : 8'h00;
      run_burst($sformatf("vec%0d", v), int'(vecs[v].len), int'(vecs[v].npush), d,
                vecs[v].starved, vecs[v].dropped);
    end

    // Back-to-back: second command right after the first done pulse.
    for (int i = 0; i < 8; i++) d[i] = 8'hC0 + 8'(i);
    clear_mon();
    push_bytes(d, 4);
    issue_cmd(1);
    wait_done("b2b first", 1, 80);
    check("b2b cmd_ready at done", 32'(cmd_ready), 32'd1);
    issue_cmd(1);
    wait_done("b2b second", 2, 80);
    repeat (2) @(negedge clk);
    check("b2b done pulses", 32'(done_cnt), 32'd2);
    check("b2b spi_en windows", 32'(en_rises), 32'd2);
    check("b2b tx_ready count", 32'(sent_q.size()), 32'd4);
    check("b2b rx_ready count", 32'(rx_cnt), 32'd4);
    for (int i = 0; i < 4 && i < sent_q.size(); i++)
      check($sformatf("b2b tx byte %0d", i), 32'(sent_q[i]), 32'(d[i]));
    check("b2b underrun", 32'(underrun), 32'd0);
    drain_rx("b2b", '{8'hC0, 8'hC1, 8'hC2, 8'hC3});

    // Reset during the second byte of an eight-byte burst.
    begin
      int t = 0;
      for (int i = 0; i < 8; i++) d[i] = 8'h10 + 8'(i);
      clear_mon();
      push_bytes(d, 4);
      issue_cmd(7);
      while (sent_q.size() < 2 && t < 60) begin @(negedge clk); t++; end
      check("midrst second byte started", 32'(sent_q.size()), 32'd2);
      repeat (3) @(negedge clk);
      check("midrst rx stored before reset", 32'(rx_empty), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("midrst spi_en async", 32'(spi_en), 32'd0);
      check("midrst rx_empty async", 32'(rx_empty), 32'd1);
      check("midrst busy async", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
      check("midrst tx_full", 32'(tx_full), 32'd0);
      check("midrst underrun", 32'(underrun), 32'd0);
    end

    // Random bursts; a leftover TX byte from the aborted burst would corrupt the first one.
    for (int r = 0; r < 8; r++) begin
      int len   = int'($urandom_range(0, 9));
      int lim   = (len + 1 < DEPTH) ? len + 1 : DEPTH;
      int npush = int'($urandom_range(0, lim));
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      run_burst($sformatf("rnd%0d", r), len, npush, d, npush < len + 1, len + 1 > DEPTH);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
